// File: rtl/fp_div_special_pipe.sv
// -----------------------------------------------------------------------------
// fp_div_special_pipe
//
// Purpose:
//   Post-processing stage for a floating-point divider. It classifies the
//   dividend and divisor and overrides the raw quotient from the divider core
//   for IEEE-style special cases: NaN, 0/0, INF/INF, x/0, 0/x, x/INF, INF/x
//   and division by one. A 3-bit class code travels with each result.
//   Subnormal operands are flushed to zero.
//
//   Two register stages:
//     S1 : operand classes, result sign, dividend magnitude, raw quotient
//     S2 : final quotient word and class code
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst_n          synchronous active-low reset
//   in_valid       dividend/divisor/raw-quotient triple valid
//   in_ready       block accepts the triple this cycle
//   data_iA        dividend        [W-1:0]
//   data_iB        divisor         [W-1:0]
//   data_o_i       raw quotient    [W-1:0]
//   out_valid      data_o/class_o valid
//   out_ready      downstream accepts data_o
//   data_o         final quotient  [W-1:0]
//   class_o        result case code [2:0]
//   flag_clr       clears the sticky flags
//   flag_invalid   sticky invalid-operation flag
//   flag_divzero   sticky divide-by-zero flag
//
//   W = 1 + EXP_W + MAN_W
//
// Configuration:
//   FP_DIV_SPECIAL_FLAGS_EN  defined   : sticky flag registers are built.
//                            undefined : both flags tied 0, flag_clr ignored.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both 1. A producer holding valid=1 while ready=0 keeps its data
// stable; ready never depends on valid of the same port.
// -----------------------------------------------------------------------------
module fp_div_special_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   data_iA,
   input  logic [EXP_W+MAN_W:0]   data_iB,
   input  logic [EXP_W+MAN_W:0]   data_o_i,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   data_o,
   output logic [2:0]             class_o,
   input  logic                   flag_clr,
   output logic                   flag_invalid,
   output logic                   flag_divzero
);

   localparam int W = 1 + EXP_W + MAN_W;

   // Operand classes
   localparam logic [2:0] OP_ZERO = 3'd0;
   localparam logic [2:0] OP_INF  = 3'd1;
   localparam logic [2:0] OP_NAN  = 3'd2;
   localparam logic [2:0] OP_ONE  = 3'd3;
   localparam logic [2:0] OP_NORM = 3'd4;

   // Result class codes
   localparam logic [2:0] RES_CORE    = 3'd0;
   localparam logic [2:0] RES_INVALID = 3'd1;
   localparam logic [2:0] RES_DIVZERO = 3'd2;
   localparam logic [2:0] RES_ZERO    = 3'd3;
   localparam logic [2:0] RES_INF     = 3'd4;
   localparam logic [2:0] RES_BYONE   = 3'd5;

   localparam logic [EXP_W-1:0] EXP_BIAS = {1'b0, {(EXP_W-1){1'b1}}};

   function automatic logic [2:0] classify(input logic [W-1:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e = x[W-2:MAN_W];
      m = x[MAN_W-1:0];
      if (e == '0)
         classify = OP_ZERO;
      else if (e == '1)
         classify = (m == '0) ? OP_INF : OP_NAN;
      else if ((e == EXP_BIAS) && (m == '0))
         classify = OP_ONE;
      else
         classify = OP_NORM;
   endfunction

   // ---------------------------------------------------------------- control
   logic w_s1_adv;
   logic w_s2_adv;
   logic w_fire;

   logic r_s1_valid;
   logic r_s2_valid;

   // S2 moves when empty or when its result is taken; S1 can take a new
   // triple when it is empty or its content moves into S2.
   assign w_s2_adv  = !r_s2_valid || out_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign in_ready  = w_s1_adv;
   assign w_fire    = r_s2_valid && out_ready;
   assign out_valid = r_s2_valid;

   // ---------------------------------------------------------------- stage 1
   logic [2:0]   r_s1_cls_a;
   logic [2:0]   r_s1_cls_b;
   logic         r_s1_sign;
   logic [W-2:0] r_s1_a_mag;
   logic [W-2:0] r_s1_q_mag;

   // The raw quotient's own sign is always replaced by sA ^ sB.
   logic w_unused_q_sign;
   assign w_unused_q_sign = data_o_i[W-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_cls_a <= OP_ZERO;
         r_s1_cls_b <= OP_ZERO;
         r_s1_sign  <= 1'b0;
         r_s1_a_mag <= '0;
         r_s1_q_mag <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_cls_a <= classify(data_iA);
            r_s1_cls_b <= classify(data_iB);
            r_s1_sign  <= data_iA[W-1] ^ data_iB[W-1];
            r_s1_a_mag <= data_iA[W-2:0];
            r_s1_q_mag <= data_o_i[W-2:0];
         end
      end
   end

   // ------------------------------------------------- case resolution (S1->S2)
   logic [W-1:0] w_res_data;
   logic [2:0]   w_res_cls;
   logic         w_a_fin;

   // ONE is an ordinary finite non-zero value for the special-case rules.
   assign w_a_fin = (r_s1_cls_a == OP_NORM) || (r_s1_cls_a == OP_ONE);

   always_comb begin
      w_res_data = {r_s1_sign, r_s1_q_mag};
      w_res_cls  = RES_CORE;
      if ((r_s1_cls_a == OP_NAN) || (r_s1_cls_b == OP_NAN) ||
          ((r_s1_cls_a == OP_ZERO) && (r_s1_cls_b == OP_ZERO)) ||
          ((r_s1_cls_a == OP_INF) && (r_s1_cls_b == OP_INF))) begin
         w_res_data = '1;
         w_res_cls  = RES_INVALID;
      end else if (r_s1_cls_b == OP_ZERO) begin
         // A is finite non-zero or INF here
         w_res_data = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_res_cls  = RES_DIVZERO;
      end else if ((r_s1_cls_a == OP_ZERO) ||
                   (w_a_fin && (r_s1_cls_b == OP_INF))) begin
         w_res_data = {r_s1_sign, {(W-1){1'b0}}};
         w_res_cls  = RES_ZERO;
      end else if (r_s1_cls_a == OP_INF) begin
         // B is finite non-zero here, including ONE
         w_res_data = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_res_cls  = RES_INF;
      end else if (r_s1_cls_b == OP_ONE) begin
         w_res_data = {r_s1_sign, r_s1_a_mag};
         w_res_cls  = RES_BYONE;
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [W-1:0] r_s2_data;
   logic [2:0]   r_s2_cls;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_cls   <= RES_CORE;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         // Bubbles leave the old word in place; out_valid=0 marks it stale.
         if (r_s1_valid) begin
            r_s2_data <= w_res_data;
            r_s2_cls  <= w_res_cls;
         end
      end
   end

   assign data_o  = r_s2_data;
   assign class_o = r_s2_cls;

   // ----------------------------------------------------------- sticky flags
`ifdef FP_DIV_SPECIAL_FLAGS_EN
   logic r_flag_invalid;
   logic r_flag_divzero;

   // A set event in the same cycle as flag_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flag_invalid <= 1'b0;
         r_flag_divzero <= 1'b0;
      end else begin
         if (w_fire && (r_s2_cls == RES_INVALID))
            r_flag_invalid <= 1'b1;
         else if (flag_clr)
            r_flag_invalid <= 1'b0;

         if (w_fire && (r_s2_cls == RES_DIVZERO))
            r_flag_divzero <= 1'b1;
         else if (flag_clr)
            r_flag_divzero <= 1'b0;
      end
   end

   assign flag_invalid = r_flag_invalid;
   assign flag_divzero = r_flag_divzero;
`else
   logic w_unused_flag_in;
   assign w_unused_flag_in = flag_clr ^ w_fire;
   assign flag_invalid     = 1'b0;
   assign flag_divzero     = 1'b0;
`endif

endmodule
